uartin: RTL and testbench

UARTIN -- requirements
Module: uartin

---
 rtl/uartin.sv | 124 ++++++++++++
 tb/tb_uartin.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uartin.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle strobes
// for a good byte, a framing error, or a byte dropped while downstream is full.
module uartin #(
  parameter int unsigned CDIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready_n,
  output logic [7:0] data,
  output logic       valid_n,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(CDIV);
  // Counter runs down to zero, so a full bit period reloads CDIV-1.
  localparam logic [CW-1:0] CNT_FULL = CW'(CDIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CDIV / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          tick;

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      cnt       <= '0;
      shreg     <= 8'h00;
      bit_idx   <= 3'd0;
      data      <= 8'h00;
      valid_n   <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      valid_n   <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end

        START: begin
          if (tick) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= CNT_FULL;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        DATA: begin
          if (tick) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= CNT_FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        // Leaving at mid stop bit lets a directly following start bit be seen.
        STOP: begin
          if (tick) begin
            if (rxs) begin
              state <= IDLE;
              if (!ready_n) begin
                data    <= shreg;
                valid_n <= 1'b0;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              state     <= BREAK;
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uartin.sv
// Randomized and directed bench for uartin; a time-offset receiver model
// predicts every output each cycle.
module tb_uartin;

  localparam int unsigned C = 8;
  localparam int unsigned H = C / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready_n;
  logic [7:0] data;
  logic       valid_n;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uartin #(.CDIV(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .ready_n  (ready_n),
    .data     (data),
    .valid_n  (valid_n),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int vectors = 0;
  int miscompares = 0;
  int step_no = 0;

  // Model: rx seen two edges late; frame decoded from offsets to the start edge.
  int         n_edge = 0;
  logic       m_s1, m_s2;
  int         mode;  // 0 idle, 1 in frame, 2 break
  int         t0;
  logic [7:0] m_byte;
  logic [7:0] exp_data;
  logic       exp_vn, exp_fe, exp_ov;

  logic prev_vn = 1'b1, prev_fe = 1'b0, prev_ov = 1'b0;
  int   n_valid = 0, n_fe = 0, n_ov = 0;
  int   last_valid_step = -1;
  logic [7:0] strobed [$];

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; mode = 0; t0 = 0; m_byte = 8'h00;
    exp_data = 8'h00; exp_vn = 1'b1; exp_fe = 1'b0; exp_ov = 1'b0;
  endtask

  task automatic model_edge(input logic rx_v, input logic rst_v, input logic rdy_v);
    logic rxs;
    int d;
    n_edge++;
    if (rst_v) begin
      model_reset();
      return;
    end
    rxs  = m_s2;
    m_s2 = m_s1;
    m_s1 = rx_v;
    exp_vn = 1'b1; exp_fe = 1'b0; exp_ov = 1'b0;
    case (mode)
      0: if (!rxs) begin t0 = n_edge; mode = 1; end
      1: begin
        d = n_edge - t0;
        if (d == int'(H)) begin
          if (rxs) mode = 0;
        end else if (d > int'(H) && d < int'(H + 9 * C) && ((d - int'(H)) % int'(C)) == 0) begin
          m_byte[(d - int'(H)) / int'(C) - 1] = rxs;
        end else if (d == int'(H + 9 * C)) begin
          if (rxs) begin
            mode = 0;
            if (!rdy_v) begin exp_data = m_byte; exp_vn = 1'b0; end
            else exp_ov = 1'b1;
          end else begin
            mode = 2;
            exp_fe = 1'b1;
          end
        end
      end
      default: if (rxs) mode = 0;
    endcase
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // One clock: compare current outputs, then apply inputs for the next edge.
  task automatic step(input logic rx_v, input logic rst_v, input logic rdy_v);
    @(negedge clk);
    vectors++;
    if (data !== exp_data || valid_n !== exp_vn || frame_err !== exp_fe || overrun !== exp_ov) begin
      miscompares++;
      $display("FAIL outputs @step %0d: got data=%h vn=%b fe=%b ov=%b want data=%h vn=%b fe=%b ov=%b",
               step_no, data, valid_n, frame_err, overrun, exp_data, exp_vn, exp_fe, exp_ov);
    end
    vectors++;
    if ((int'(!valid_n) + int'(frame_err) + int'(overrun)) > 1 ||
        (!valid_n && !prev_vn) || (frame_err && prev_fe) || (overrun && prev_ov)) begin
      miscompares++;
      $display("FAIL strobe_excl @step %0d: got vn=%b fe=%b ov=%b prev vn=%b fe=%b ov=%b want single 1-cycle strobes",
               step_no, valid_n, frame_err, overrun, prev_vn, prev_fe, prev_ov);
    end
    if (valid_n === 1'b0) begin n_valid++; last_valid_step = step_no; strobed.push_back(data); end
    if (frame_err === 1'b1) n_fe++;
    if (overrun === 1'b1) n_ov++;
    prev_vn = valid_n; prev_fe = frame_err; prev_ov = overrun;
    rx = rx_v; rst = rst_v; ready_n = rdy_v;
    model_edge(rx_v, rst_v, rdy_v);
    step_no++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'(($urandom_range(0, 1))));
  endtask

  // Bits 0..nbits-1 of the 10-bit frame, each C cycles; rnd_rdy randomizes ready_n per cycle.
  task automatic send_bits(input logic [7:0] b, input logic stop_v, input logic rdy,
                           input bit rnd_rdy, input int nbits);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < nbits; i++)
      repeat (C) step(fr[i], 1'b0, rnd_rdy ? 1'($urandom_range(0, 1)) : rdy);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic rdy);
    send_bits(b, stop_v, rdy, 1'b0, 10);
  endtask

  initial begin
    int s0, v0, f0, o0;
    logic [7:0] rb;
    rx = 1'b1; ready_n = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    step(1'b1, 1'b0, 1'b0);
    check("reset_data", int'(data), 8'h00);
    check("reset_valid_n", int'(valid_n), 1);
    check("reset_frame_err", int'(frame_err), 0);
    idle(10);

    // 0x55 with room downstream: strobe 2 sync + H + 9C + 1 register steps later
    s0 = step_no; v0 = n_valid;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(2 * C);
    check("f55_strobes", n_valid - v0, 1);
    check("f55_data", int'(data), 8'h55);
    check("f55_latency", last_valid_step - s0, 79);

    // False start: two-cycle glitch
    v0 = n_valid; f0 = n_fe; o0 = n_ov;
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
    idle(30);
    check("glitch_events", (n_valid - v0) + (n_fe - f0) + (n_ov - o0), 0);

    // Bad stop bit, line held low 40 cycles more
    v0 = n_valid; f0 = n_fe;
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b0, 1'b0);
    idle(30);
    check("fe_pulses", n_fe - f0, 1);
    check("fe_no_valid", n_valid - v0, 0);
    check("fe_data_kept", int'(data), 8'h55);

    // Downstream full: overrun, data kept
    v0 = n_valid; o0 = n_ov;
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(2 * C);
    check("ov_pulses", n_ov - o0, 1);
    check("ov_no_valid", n_valid - v0, 0);
    check("ov_data_kept", int'(data), 8'h55);

    // Back-to-back frames with zero idle gap
    v0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2 * C);
    check("b2b_strobes", n_valid - v0, 2);
    if (strobed.size() >= 2) begin
      check("b2b_first", int'(strobed[strobed.size() - 2]), 8'h00);
      check("b2b_second", int'(strobed[strobed.size() - 1]), 8'hFF);
    end

    // Reset mid bit 4 of 0x81, then a clean 0x42
    v0 = n_valid; f0 = n_fe; o0 = n_ov;
    send_bits(8'h81, 1'b1, 1'b0, 1'b0, 5);
    repeat (H) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    idle(20);
    check("rst_abort_quiet", (n_valid - v0) + (n_fe - f0) + (n_ov - o0), 0);
    check("rst_data_cleared", int'(data), 8'h00);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(2 * C);
    check("rst_then_42_strobes", n_valid - v0, 1);
    check("rst_then_42_data", int'(data), 8'h42);

    // Random traffic: gaps, glitches, bad stops, random ready_n, occasional resets
    for (int k = 0; k < 300; k++) begin
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 19))
        0: begin
          repeat ($urandom_range(1, H - 1)) step(1'b0, 1'b0, 1'b0);
        end
        1: begin
          send_bits(rb, 1'b1, 1'b0, 1'b1, int'($urandom_range(1, 9)));
          repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        2, 3: begin
          send_bits(rb, 1'b0, 1'b0, 1'b1, 10);
          repeat ($urandom_range(0, 20)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        default: send_bits(rb, 1'b1, 1'b0, 1'b1, 10);
      endcase
      idle(int'($urandom_range(0, 12)));
    end
    idle(3 * C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
